// File: rtl/ddr_maint_cmd_exec.sv
// Maintenance command executor: runs PREA -> REF/MRS -> recovery sequences on the
// DDR4 command bus in response to single-cycle refresh / MR0-update requests.
module ddr_maint_cmd_exec #(
   parameter int unsigned T_RP      = 12,
   parameter int unsigned T_RFC     = 208,
   parameter int unsigned T_MOD     = 24,
   parameter int unsigned MRS_WIDTH = 14,
   parameter int unsigned CNT_WIDTH = 9
) (
   input  logic                 clock_t,
   input  logic                 reset,
   input  logic                 refresh_rdy,
   input  logic                 mrs_update_rdy,
   input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
   output logic                 cs_n,
   output logic                 act_n,
   output logic                 ras_n_a16,
   output logic                 cas_n_a15,
   output logic                 we_n_a14,
   output logic [1:0]           bg,
   output logic [1:0]           ba,
   output logic [MRS_WIDTH-1:0] addr,
   output logic                 maint_bus_own,
   output logic                 maint_busy,
   output logic                 refresh_done,
   output logic                 update_done,
   output logic                 req_dropped
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREA, S_WAIT_RP, S_ISSUE, S_WAIT_REC, S_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 pend_ref, pend_ref_nxt, pend_mrs, pend_mrs_nxt;
   logic                 clr_ref, clr_mrs, drop;
   logic                 seq_ref, seq_ref_nxt;
   logic [MRS_WIDTH-1:0] op_pend, op_pend_nxt, op_act, op_act_nxt;
   logic [4:0]           ctl_nxt;
   logic [1:0]           bg_nxt, ba_nxt;
   logic [MRS_WIDTH-1:0] addr_nxt;

   // Outputs are registered from the next-state decode, so the counter is loaded
   // on entry to PREA/ISSUE; this places ISSUE exactly T_RP cycles after PREA.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      seq_ref_nxt = seq_ref;
      op_act_nxt  = op_act;
      clr_ref     = 1'b0;
      clr_mrs     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pend_ref) begin
               state_nxt   = S_PREA;
               seq_ref_nxt = 1'b1;
               clr_ref     = 1'b1;
               cnt_nxt     = CNT_WIDTH'(T_RP - 1);
            end else if (pend_mrs) begin
               state_nxt   = S_PREA;
               seq_ref_nxt = 1'b0;
               clr_mrs     = 1'b1;
               op_act_nxt  = op_pend;
               cnt_nxt     = CNT_WIDTH'(T_RP - 1);
            end
         end
         S_PREA: begin
            state_nxt = S_WAIT_RP;
            cnt_nxt   = cnt - CNT_WIDTH'(1);
         end
         S_WAIT_RP: begin
            if (cnt == '0) begin
               state_nxt = S_ISSUE;
               cnt_nxt   = seq_ref ? CNT_WIDTH'(T_RFC - 1) : CNT_WIDTH'(T_MOD - 1);
            end else begin
               cnt_nxt = cnt - CNT_WIDTH'(1);
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_REC;
            cnt_nxt   = cnt - CNT_WIDTH'(1);
         end
         S_WAIT_REC: begin
            if (cnt == '0) state_nxt = S_DONE;
            else           cnt_nxt   = cnt - CNT_WIDTH'(1);
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // A pulse landing on the cycle its flag is consumed re-arms it rather than merging
      pend_ref_nxt = (pend_ref & ~clr_ref) | refresh_rdy;
      pend_mrs_nxt = (pend_mrs & ~clr_mrs) | mrs_update_rdy;
      drop         = (refresh_rdy & pend_ref & ~clr_ref) |
                     (mrs_update_rdy & pend_mrs & ~clr_mrs);
      op_pend_nxt  = mrs_update_rdy ? mrs_update_cmd : op_pend;

      ctl_nxt  = 5'b11111;
      bg_nxt   = '0;
      ba_nxt   = '0;
      addr_nxt = '0;
      if (state_nxt == S_PREA) begin
         ctl_nxt      = 5'b01010;
         addr_nxt[10] = 1'b1;
      end else if (state_nxt == S_ISSUE) begin
         if (seq_ref_nxt) begin
            ctl_nxt = 5'b01001;
         end else begin
            ctl_nxt  = 5'b01000;
            addr_nxt = op_act_nxt;
         end
      end
   end

   always_ff @(posedge clock_t) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         pend_ref      <= 1'b0;
         pend_mrs      <= 1'b0;
         seq_ref       <= 1'b0;
         op_pend       <= '0;
         op_act        <= '0;
         {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= 5'b11111;
         bg            <= '0;
         ba            <= '0;
         addr          <= '0;
         maint_bus_own <= 1'b0;
         maint_busy    <= 1'b0;
         refresh_done  <= 1'b0;
         update_done   <= 1'b0;
         req_dropped   <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         pend_ref      <= pend_ref_nxt;
         pend_mrs      <= pend_mrs_nxt;
         seq_ref       <= seq_ref_nxt;
         op_pend       <= op_pend_nxt;
         op_act        <= op_act_nxt;
         {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} <= ctl_nxt;
         bg            <= bg_nxt;
         ba            <= ba_nxt;
         addr          <= addr_nxt;
         maint_bus_own <= (state_nxt != S_IDLE);
         maint_busy    <= (state_nxt != S_IDLE) | pend_ref_nxt | pend_mrs_nxt;
         refresh_done  <= (state_nxt == S_DONE) & seq_ref_nxt;
         update_done   <= (state_nxt == S_DONE) & ~seq_ref_nxt;
         req_dropped   <= req_dropped | drop;
      end
   end

endmodule

// File: tb/tb_ddr_maint_cmd_exec.sv
// Bench for ddr_maint_cmd_exec: directed scenarios plus random requests against a
// timeline model (each sequence is an offset window from its PREA cycle).
module tb_ddr_maint_cmd_exec;

   localparam int unsigned T_RP  = 12;
   localparam int unsigned T_RFC = 208;
   localparam int unsigned T_MOD = 24;
   localparam int unsigned MW    = 14;

   logic          clock_t = 1'b0;
   logic          reset = 1'b1;
   logic          refresh_rdy = 1'b0;
   logic          mrs_update_rdy = 1'b0;
   logic [MW-1:0] mrs_update_cmd = '0;
   logic          cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
   logic [1:0]    bg, ba;
   logic [MW-1:0] addr;
   logic          maint_bus_own, maint_busy, refresh_done, update_done, req_dropped;

   ddr_maint_cmd_exec #(
      .T_RP(T_RP), .T_RFC(T_RFC), .T_MOD(T_MOD), .MRS_WIDTH(MW), .CNT_WIDTH(9)
   ) dut (
      .clock_t(clock_t), .reset(reset), .refresh_rdy(refresh_rdy),
      .mrs_update_rdy(mrs_update_rdy), .mrs_update_cmd(mrs_update_cmd),
      .cs_n(cs_n), .act_n(act_n), .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15),
      .we_n_a14(we_n_a14), .bg(bg), .ba(ba), .addr(addr),
      .maint_bus_own(maint_bus_own), .maint_busy(maint_busy),
      .refresh_done(refresh_done), .update_done(update_done), .req_dropped(req_dropped)
   );

   always #5 clock_t = ~clock_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ref_seen = 0;

   // reference model: pending flags plus the PREA cycle of the active sequence
   bit          m_act = 0, m_ref = 0, m_pr = 0, m_pm = 0, m_drop = 0;
   int          m_start = 0;
   logic [MW-1:0] m_op = '0, m_seq_op = '0;

   localparam logic [22:0] DESEL = {5'b11111, 4'b0000, 14'h0000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int unsigned rec_len(input bit is_ref);
      return is_ref ? T_RFC : T_MOD;
   endfunction

   function automatic logic [22:0] exp_bus();
      int d;
      logic [22:0] b;
      b = DESEL;
      if (m_act) begin
         d = cyc - m_start;
         if (d == 0) b = {5'b01010, 4'b0000, 14'h0400};
         else if (d == int'(T_RP)) b = m_ref ? {5'b01001, 4'b0000, 14'h0000}
                                             : {5'b01000, 4'b0000, m_seq_op};
      end
      return b;
   endfunction

   task automatic model_edge(input bit rst, input bit rr, input bit mr, input logic [MW-1:0] op);
      bit was_idle, cr, cm;
      cr = 0; cm = 0;
      if (rst) begin
         m_act = 0; m_pr = 0; m_pm = 0; m_drop = 0; m_op = '0;
         return;
      end
      was_idle = !m_act;
      if (m_act && (cyc - m_start) == int'(T_RP + rec_len(m_ref) + 1)) m_act = 0;
      if (was_idle && (m_pr || m_pm)) begin
         m_act = 1;
         m_start = cyc;
         m_ref = m_pr;
         if (m_pr) cr = 1;
         else begin cm = 1; m_seq_op = m_op; end
      end
      if ((rr && m_pr && !cr) || (mr && m_pm && !cm)) m_drop = 1;
      m_pr = (m_pr && !cr) || rr;
      m_pm = (m_pm && !cm) || mr;
      if (mr) m_op = op;
   endtask

   task automatic step(input bit rst, input bit rr, input bit mr, input logic [MW-1:0] op);
      bit dpulse_r, dpulse_u;
      logic [22:0] eb;
      int d;
      @(negedge clock_t);
      reset = rst; refresh_rdy = rr; mrs_update_rdy = mr; mrs_update_cmd = op;
      @(posedge clock_t);
      cyc++;
      model_edge(rst, rr, mr, op);
      #1;
      eb = exp_bus();
      d = cyc - m_start;
      dpulse_r = m_act && m_ref && d == int'(T_RP + T_RFC);
      dpulse_u = m_act && !m_ref && d == int'(T_RP + T_MOD);
      check("bus", 32'({cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, addr}), 32'(eb));
      check("bus_own", 32'(maint_bus_own), 32'(m_act));
      check("busy", 32'(maint_busy), 32'(m_act || m_pr || m_pm));
      check("refresh_done", 32'(refresh_done), 32'(dpulse_r));
      check("update_done", 32'(update_done), 32'(dpulse_u));
      check("req_dropped", 32'(req_dropped), 32'(m_drop));
      if ({cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14} == 5'b01001) ref_seen++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0);
   endtask

   initial begin
      // single refresh, request sampled on cycle 10 after reset
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
      idle(6);
      step(0, 1, 0, '0);
      idle(240);

      // MRS update with a known opcode
      step(1, 0, 0, '0);
      idle(3);
      step(0, 0, 1, 14'h0A52);
      idle(50);

      // simultaneous requests: refresh first, then MRS
      step(0, 1, 1, 14'h1234);
      idle(290);

      // second refresh pending during execution, third one merged
      step(1, 0, 0, '0);
      ref_seen = 0;
      step(0, 1, 0, '0);
      idle(20);
      step(0, 1, 0, '0);
      idle(5);
      step(0, 1, 0, '0);
      idle(480);
      check("ref_count", 32'(ref_seen), 32'd2);

      // reset 4 cycles into the recovery wait
      step(1, 0, 0, '0);
      step(0, 1, 0, '0);
      idle(T_RP + 4);
      step(1, 0, 0, '0);
      idle(10);

      // MRS opcode overwritten while pending behind a refresh
      step(0, 1, 0, '0);
      idle(30);
      step(0, 0, 1, 14'h0111);
      idle(10);
      step(0, 0, 1, 14'h2222);
      idle(260);

      // random traffic with occasional reset
      step(1, 0, 0, '0);
      for (int i = 0; i < 12000; i++) begin
         step($urandom_range(0, 2999) == 0, $urandom_range(0, 69) == 0,
              $urandom_range(0, 49) == 0, MW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
